// File: rtl/time_dmr_pkg.sv
// Shared types for the temporal DMR wrapper: default payload/ID shapes and
// the start-side FSM state.
package time_dmr_pkg;

  localparam int unsigned ID_SIZE = 4;

  typedef logic [7:0] data_t;

  typedef struct packed {
    data_t              data;
    logic [ID_SIZE-1:0] id;
  } item_t;

  typedef enum logic [0:0] {
    BASE = 1'b0,
    REPL = 1'b1
  } start_state_e;

endpackage

// File: rtl/time_dmr_if.sv
// Redundant copy bus: one tagged copy per valid/ready handshake.
interface time_dmr_if #(
  parameter type         DataType = time_dmr_pkg::data_t,
  parameter int unsigned IDSize   = time_dmr_pkg::ID_SIZE
) ();

  DataType           data;
  logic [IDSize-1:0] id;
  logic              valid;
  logic              ready;

  modport master (output data, output id, output valid, input ready);
  modport slave  (input data, input id, input valid, output ready);

endinterface

// File: rtl/time_dmr_checker.sv
// End side of the temporal DMR pair: pairs the two copies of each item by ID
// and emits one (possibly retry-flagged) result per item.
module time_dmr_checker
  import time_dmr_pkg::*;
#(
  parameter type         DataType    = data_t,
  parameter int unsigned IDSize      = ID_SIZE,
  parameter int unsigned LockTimeout = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  time_dmr_if.slave         red,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              needs_retry_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              lock_o,
  output logic              fault_detected_o
);

  typedef logic [IDSize-1:0] id_t;

  localparam int unsigned    CW       = $clog2(LockTimeout + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(LockTimeout - 1);

  // Pending-copy slot; when occupied it always holds the copy for ID e_q.
  logic          p_valid_q, p_faulty_q;
  DataType       p_data_q;
  id_t           e_q;
  logic [CW-1:0] cnt_q;

  logic          out_valid_q, out_retry_q, fault_q;
  DataType       out_data_q;
  id_t           out_id_q;

  logic          out_free, copy_hs, timeout;
  id_t           e_next_id, e_prev_id;

  logic          emit, emit_retry;
  DataType       emit_data;
  id_t           emit_id;
  logic          p_valid_d, p_faulty_d;
  DataType       p_data_d;
  id_t           e_d;

  assign out_free  = !out_valid_q || ready_i;
  assign red.ready = out_free;
  assign copy_hs   = red.valid && out_free;
  assign e_next_id = e_q + id_t'(1);
  assign e_prev_id = e_q - id_t'(1);
  assign timeout   = enable_i && p_valid_q && !copy_hs && (cnt_q == CNT_LAST) && out_free;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    emit       = 1'b0;
    emit_retry = 1'b0;
    emit_data  = p_data_q;
    emit_id    = e_q;
    p_valid_d  = p_valid_q;
    p_faulty_d = p_faulty_q;
    p_data_d   = p_data_q;
    e_d        = e_q;

    if (!enable_i) begin
      p_valid_d = 1'b0;
      if (copy_hs) begin
        emit      = 1'b1;
        emit_data = red.data;
        emit_id   = red.id;
        e_d       = red.id + id_t'(1);
      end
    end else if (copy_hs) begin
      // A copy tagged E-1 belongs to an item already emitted and is dropped.
      if (red.id != e_prev_id) begin
        if (!p_valid_q) begin
          p_valid_d  = 1'b1;
          p_data_d   = red.data;
          p_faulty_d = (red.id != e_q);
        end else if (red.id == e_next_id) begin
          emit       = 1'b1;
          emit_retry = 1'b1;
          p_data_d   = red.data;
          p_faulty_d = 1'b0;
          e_d        = e_next_id;
        end else begin
          emit       = 1'b1;
          emit_retry = p_faulty_q || (red.id != e_q) || (red.data != p_data_q);
          p_valid_d  = 1'b0;
          e_d        = e_next_id;
        end
      end
    end else if (timeout) begin
      emit       = 1'b1;
      emit_retry = 1'b1;
      p_valid_d  = 1'b0;
      e_d        = e_next_id;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_valid_q   <= 1'b0;
      p_faulty_q  <= 1'b0;
      p_data_q    <= '0;
      e_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_retry_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      fault_q     <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      p_valid_q  <= p_valid_d;
      p_faulty_q <= p_faulty_d;
      p_data_q   <= p_data_d;
      e_q        <= e_d;
      fault_q    <= emit && emit_retry;

      if (emit) begin
        out_valid_q <= 1'b1;
        out_retry_q <= emit_retry;
        out_data_q  <= emit_data;
        out_id_q    <= emit_id;
      end else if (ready_i) begin
        out_valid_q <= 1'b0;
      end

      // Idle counter restarts on every arriving copy and whenever the slot empties.
      if (!enable_i || !p_valid_q || copy_hs || timeout) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign data_o           = out_data_q;
  assign id_o             = out_id_q;
  assign needs_retry_o    = out_retry_q;
  assign valid_o          = out_valid_q;
  assign lock_o           = p_valid_q;
  assign fault_detected_o = fault_q;

endmodule

// File: rtl/time_dmr_pair.sv
// Temporal DMR wrapper: sends each upstream item out twice with a rolling ID
// and checks the two returning copies against each other.
module time_dmr_pair
  import time_dmr_pkg::*;
#(
  parameter type         DataType    = data_t,
  parameter int unsigned IDSize      = ID_SIZE,
  parameter int unsigned LockTimeout = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  time_dmr_if.master        red_o,
  time_dmr_if.slave         red_i,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              needs_retry_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              lock_o,
  output logic              fault_detected_o
);

  start_state_e      state_q;
  logic [IDSize-1:0] ni_q;
  logic              red_hs;

  // Upstream is only released once the second copy has been handed off.
  assign red_o.data  = data_i;
  assign red_o.id    = ni_q;
  assign red_o.valid = (enable_i && state_q == REPL) ? 1'b1 : valid_i;
  assign red_hs      = red_o.valid && red_o.ready;
  assign ready_o     = (!enable_i || state_q == REPL) && red_o.ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BASE;
      ni_q    <= '0;
    end else begin
      if (!enable_i) begin
        state_q <= BASE;
      end else if (red_hs) begin
        state_q <= (state_q == BASE) ? REPL : BASE;
      end
      if (red_hs && (!enable_i || state_q == REPL)) begin
        ni_q <= ni_q + 1'b1;
      end
    end
  end

  time_dmr_checker #(
    .DataType    (DataType),
    .IDSize      (IDSize),
    .LockTimeout (LockTimeout)
  ) u_checker (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .enable_i         (enable_i),
    .red              (red_i),
    .data_o           (data_o),
    .id_o             (id_o),
    .needs_retry_o    (needs_retry_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .lock_o           (lock_o),
    .fault_detected_o (fault_detected_o)
  );

endmodule

// File: tb/tb_time_dmr_pair.sv
// Directed bench for time_dmr_pair: loops the redundant bus back with
// selectable fault injection on individual copies.
module tb_time_dmr_pair;
  import time_dmr_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] id;
    logic       retry;
    logic       fault;
  } res_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       enable;
  logic [7:0] data_i;
  logic       valid_i, ready_o;
  logic [7:0] data_o;
  logic [3:0] id_o;
  logic       needs_retry_o, valid_o, ready_i, lock_o, fault_detected_o;

  time_dmr_if #(.DataType(logic [7:0]), .IDSize(4)) red_o_if ();
  time_dmr_if #(.DataType(logic [7:0]), .IDSize(4)) red_i_if ();

  time_dmr_pair #(.DataType(logic [7:0]), .IDSize(4), .LockTimeout(4)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .enable_i         (enable),
    .data_i           (data_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .red_o            (red_o_if),
    .red_i            (red_i_if),
    .data_o           (data_o),
    .id_o             (id_o),
    .needs_retry_o    (needs_retry_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .lock_o           (lock_o),
    .fault_detected_o (fault_detected_o)
  );

  always #5 clk_i = ~clk_i;

  // Loopback path with targeted corruption of one copy.
  logic [3:0] tgt_id;
  logic       tgt_copy, do_xor, do_idflip, do_drop, spur;
  logic [3:0] spur_id;
  logic [7:0] spur_data;
  logic       copy_n, hit;

  assign hit            = red_o_if.valid && (red_o_if.id == tgt_id) && (copy_n == tgt_copy);
  assign red_i_if.valid = spur || (red_o_if.valid && !(do_drop && hit));
  assign red_i_if.data  = spur ? spur_data : (red_o_if.data ^ ((do_xor && hit) ? 8'hFF : 8'h00));
  assign red_i_if.id    = spur ? spur_id : (red_o_if.id ^ {3'b000, do_idflip && hit});
  assign red_o_if.ready = (do_drop && hit) ? 1'b1 : red_i_if.ready;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) copy_n <= 1'b0;
    else if (enable && red_o_if.valid && red_o_if.ready) copy_n <= ~copy_n;
  end

  // Monitors
  int    cyc = 0;
  int    lock_cnt = 0;
  int    fault_cnt = 0;
  res_t  res_q[$];
  item_t red_log[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (valid_o && ready_i) res_q.push_back('{data_o, id_o, needs_retry_o, fault_detected_o});
      if (red_o_if.valid && red_o_if.ready) red_log.push_back('{red_o_if.data, red_o_if.id});
      if (lock_o) lock_cnt <= lock_cnt + 1;
      if (fault_detected_o) fault_cnt <= fault_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    data_i  = d;
    valid_i = 1'b1;
    do begin
      @(negedge clk_i);
      n++;
    end while (!ready_o && n < 50);
    if (!ready_o) check("send_timeout", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_results(input int n, input string tag);
    int k = 0;
    while (res_q.size() < n && k < 40) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    check(tag, 32'(res_q.size()), 32'(n));
  endtask

  logic [7:0] sent[100];
  int         t0, lk0;

  // Expected results of the redundant-mode run: {data, id, retry}.
  logic [12:0] exp_red[8] = '{
    {8'h11, 4'd0, 1'b0}, {8'h22, 4'd1, 1'b0}, {8'h33, 4'd2, 1'b1}, {8'h44, 4'd3, 1'b0},
    {8'h55, 4'd4, 1'b0}, {8'h66, 4'd5, 1'b1}, {8'h77, 4'd6, 1'b0}, {8'h88, 4'd7, 1'b1}
  };
  item_t exp_log[4] = '{'{8'h11, 4'd0}, '{8'h11, 4'd0}, '{8'h22, 4'd1}, '{8'h22, 4'd1}};

  initial begin
    rst_ni = 1'b0; enable = 1'b0; data_i = '0; valid_i = 1'b0; ready_i = 1'b1;
    tgt_id = '0; tgt_copy = 1'b0; do_xor = 1'b0; do_idflip = 1'b0; do_drop = 1'b0;
    spur = 1'b0; spur_id = '0; spur_data = '0;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_lock_o", 32'(lock_o), 32'd0);
    check("rst_fault", 32'(fault_detected_o), 32'd0);
    check("rst_retry", 32'(needs_retry_o), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Pass-through: one item per cycle, data and ID straight through.
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      sent[i] = 8'($urandom_range(0, 255));
      send(sent[i]);
    end
    check("pt_rate", 32'(cyc - t0), 32'd100);
    wait_results(100, "pt_count");
    for (int i = 0; i < 100; i++)
      check("pt_item", 32'({res_q[i].id, res_q[i].data, res_q[i].retry}),
            32'({4'(i), sent[i], 1'b0}));

    // Reset mid-stream, then redundant mode from ID 0.
    rst_ni = 1'b0;
    enable = 1'b1;
    @(negedge clk_i);
    check("rst2_valid_o", 32'(valid_o), 32'd0);
    check("rst2_red_valid", 32'(red_o_if.valid), 32'd0);
    check("rst2_red_id", 32'(red_o_if.id), 32'd0);
    check("rst2_ready_o", 32'(ready_o), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    t0 = cyc;
    send(8'h11);
    send(8'h22);
    check("dmr_rate", 32'(cyc - t0), 32'd4);
    wait_results(102, "dmr_count");
    for (int k = 0; k < 4; k++)
      check("red_copy", 32'(red_log[100 + k]), 32'(exp_log[k]));

    // Corrupt the second copy of ID2.
    tgt_id = 4'd2; tgt_copy = 1'b1; do_xor = 1'b1;
    send(8'h33);
    do_xor = 1'b0;
    send(8'h44);
    wait_results(104, "xor_count");

    // Spurious late copy of ID3 once it has completed.
    repeat (2) @(posedge clk_i);
    #1;
    spur = 1'b1; spur_id = 4'd3; spur_data = 8'h44;
    @(posedge clk_i);
    #1 spur = 1'b0;
    repeat (4) @(negedge clk_i);
    check("spur_count", 32'(res_q.size()), 32'd104);
    check("spur_lock", 32'(lock_o), 32'd0);

    // Flip ID bit 0 on the second copy of ID5.
    send(8'h55);
    tgt_id = 4'd5; tgt_copy = 1'b1; do_idflip = 1'b1;
    send(8'h66);
    do_idflip = 1'b0;
    send(8'h77);
    wait_results(107, "idflip_count");

    // Lose the second copy of the final item: timeout must release it.
    lk0 = lock_cnt;
    tgt_id = 4'd7; tgt_copy = 1'b1; do_drop = 1'b1;
    send(8'h88);
    do_drop = 1'b0;
    wait_results(108, "drop_count");
    check("drop_lock_cycles", 32'(lock_cnt - lk0), 32'd4);
    check("drop_lock_off", 32'(lock_o), 32'd0);

    repeat (6) @(negedge clk_i);
    #1;
    check("final_count", 32'(res_q.size()), 32'd108);
    for (int k = 0; k < 8; k++) begin
      check("dmr_result", 32'({res_q[100 + k].data, res_q[100 + k].id, res_q[100 + k].retry}),
            32'(exp_red[k]));
      check("fault_pulse", 32'(res_q[100 + k].fault), 32'(exp_red[k][0]));
    end
    check("fault_total", 32'(fault_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
